cic_rate_ctrl: RTL

//  Sequences run-time decimation-rate changes for a variable-rate cic_d instance.

---
 rtl/cic_pkg.sv | 26 ++
 rtl/cic_rate_ctrl_if.sv | 33 +++
 rtl/cic_rate_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared types and helpers for the CIC rate-change controller.
//                - rate_ctrl_state_t : controller FSM state encoding
//                - settle_count()    : number of corrupted CIC outputs to mask
//                                      after a rate change (N*M + 1)
//  Revision    : 1.0  initial release
// ============================================================================
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } rate_ctrl_state_t;

  // After a rate load the comb chain holds stale history for N*M samples,
  // plus the first output whose integrator value straddled the change.
  function automatic int settle_count(input int n, input int m);
    return n * m + 1;
  endfunction

endpackage : cic_pkg
`default_nettype wire

// File: rtl/cic_rate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cic_rate_ctrl_if
//  Description : Valid/ready stream carrying decimation-rate requests from the
//                control plane into the rate-change controller.
//  Ports       : tdata  - requested decimation ratio (RATE_DW bits)
//                tvalid - request valid (driven by master)
//                tready - request accepted on valid&ready at a clk edge
//                         (driven by slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface cic_rate_ctrl_if #(
  parameter int RATE_DW = 32
);

  logic [RATE_DW-1:0] tdata;
  logic               tvalid;
  logic               tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface : cic_rate_ctrl_if
`default_nettype wire

// File: rtl/cic_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cic_rate_ctrl
//  Description : Sequences run-time decimation-rate changes for a variable-rate
//                CIC decimator. A legal, different rate request gates the
//                input sample strobe for FLUSH_CYC cycles so the integrators
//                drain, issues a single-cycle rate load, then masks the first
//                CIC_N*CIC_M+1 CIC outputs while the comb chain refills.
//                Sample data never passes through this block.
//  Ports       : clk                   - clock
//                reset_n               - asynchronous active-low reset
//                s_axis_req            - rate request stream (slave modport)
//                s_axis_in_tvalid      - upstream sample strobe
//                m_axis_cic_in_tvalid  - gated strobe to CIC input
//                m_axis_rate_tdata     - rate word to CIC
//                m_axis_rate_tvalid    - one-cycle rate load pulse to CIC
//                s_axis_cic_out_tvalid - CIC output strobe
//                m_axis_out_tvalid     - masked output strobe to downstream
//                current_rate          - rate in force
//                busy                  - high whenever the FSM is not IDLE
//                rate_err              - one-cycle pulse on illegal request
//                drop_cnt              - saturating count of gated strobes
//                                        during the most recent change
//  Revision    : 1.0  initial release
// ============================================================================
module cic_rate_ctrl
  import cic_pkg::*;
#(
  parameter int RATE_DW   = 32,
  parameter int CIC_R     = 10,
  parameter int CIC_N     = 7,
  parameter int CIC_M     = 1,
  parameter int FLUSH_CYC = 16,
  parameter int CNT_DW    = 16
) (
  input  wire                clk,
  input  wire                reset_n,
  cic_rate_ctrl_if.slave     s_axis_req,
  input  wire                s_axis_in_tvalid,
  output logic               m_axis_cic_in_tvalid,
  output logic [RATE_DW-1:0] m_axis_rate_tdata,
  output logic               m_axis_rate_tvalid,
  input  wire                s_axis_cic_out_tvalid,
  output logic               m_axis_out_tvalid,
  output logic [RATE_DW-1:0] current_rate,
  output logic               busy,
  output logic               rate_err,
  output logic [CNT_DW-1:0]  drop_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_SETTLE_N = settle_count(CIC_N, CIC_M);
  localparam int c_FL_W     = (FLUSH_CYC  > 1) ? $clog2(FLUSH_CYC)  : 1;
  localparam int c_ST_W     = (c_SETTLE_N > 1) ? $clog2(c_SETTLE_N) : 1;

  localparam logic [c_FL_W-1:0]  c_FL_LAST = c_FL_W'(FLUSH_CYC - 1);
  localparam logic [c_ST_W-1:0]  c_ST_LAST = c_ST_W'(c_SETTLE_N - 1);
  localparam logic [RATE_DW-1:0] c_RMAX    = RATE_DW'(CIC_R);
  localparam logic [CNT_DW-1:0]  c_DROP_SAT = {CNT_DW{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  rate_ctrl_state_t    r_state;
  logic                r_tready;
  logic                r_gate;
  logic                r_mask;
  logic                r_rate_tvalid;
  logic                r_rate_err;
  logic [RATE_DW-1:0]  r_rate_tdata;
  logic [RATE_DW-1:0]  r_cur_rate;
  logic [RATE_DW-1:0]  r_req_rate;
  logic [c_FL_W-1:0]   r_flush_cnt;
  logic [c_ST_W-1:0]   r_settle_cnt;
  logic [CNT_DW-1:0]   r_drop_cnt;

  logic                w_req_hs;
  logic                w_req_illegal;

  assign w_req_hs      = s_axis_req.tvalid & r_tready;
  assign w_req_illegal = (s_axis_req.tdata == '0) || (s_axis_req.tdata > c_RMAX);

  // --------------------------------------------------------------------------
  // Controller FSM. Every output transition is registered together with the
  // state move, so the gate/mask flags and the rate pulse line up with the
  // state they belong to (gate clears and rate pulses on entry to APPLY).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tready      <= 1'b0;
      r_gate        <= 1'b0;
      r_mask        <= 1'b0;
      r_rate_tvalid <= 1'b0;
      r_rate_err    <= 1'b0;
      r_rate_tdata  <= c_RMAX;
      r_cur_rate    <= c_RMAX;
      r_req_rate    <= c_RMAX;
      r_flush_cnt   <= '0;
      r_settle_cnt  <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_rate_tvalid <= 1'b0;
      r_rate_err    <= 1'b0;

      case (r_state)
        IDLE: begin
          r_tready <= 1'b1;
          if (w_req_hs) begin
            r_req_rate <= s_axis_req.tdata;
            if (w_req_illegal) begin
              r_rate_err <= 1'b1;
            end else if (s_axis_req.tdata != r_cur_rate) begin
              r_drop_cnt  <= '0;
              r_gate      <= 1'b1;
              r_flush_cnt <= '0;
              r_tready    <= 1'b0;
              r_state     <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (r_gate && s_axis_in_tvalid && (r_drop_cnt != c_DROP_SAT)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
          end
          if (r_flush_cnt == c_FL_LAST) begin
            r_gate        <= 1'b0;
            r_mask        <= 1'b1;
            r_rate_tvalid <= 1'b1;
            r_rate_tdata  <= r_req_rate;
            r_cur_rate    <= r_req_rate;
            r_state       <= APPLY;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end

        APPLY: begin
          r_settle_cnt <= '0;
          r_state      <= SETTLE;
        end

        SETTLE: begin
          if (s_axis_cic_out_tvalid) begin
            if (r_settle_cnt == c_ST_LAST) begin
              // Last corrupted output is still masked this cycle; the
              // next one goes downstream and a new request may be taken.
              r_mask   <= 1'b0;
              r_tready <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis_req.tready    = r_tready;
  assign m_axis_cic_in_tvalid = s_axis_in_tvalid & ~r_gate;
  assign m_axis_out_tvalid    = s_axis_cic_out_tvalid & ~r_mask;
  assign m_axis_rate_tdata    = r_rate_tdata;
  assign m_axis_rate_tvalid   = r_rate_tvalid;
  assign current_rate         = r_cur_rate;
  assign busy                 = (r_state != IDLE);
  assign rate_err             = r_rate_err;
  assign drop_cnt             = r_drop_cnt;

endmodule : cic_rate_ctrl
`default_nettype wire
